// File: rtl/huff_fix_pkg.sv
// Shared types, constants and helpers for the fixed-Huffman (BTYPE=01) deflate token encoder.
// HUFF_FIX_ZLIB_HDR_EN adds the ZHDR state that emits the zlib CMF/FLG field before the block header.
package huff_fix_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_TOK  = 3'd2,
    ST_DST  = 3'd3,
    ST_EOB  = 3'd4
`ifdef HUFF_FIX_ZLIB_HDR_EN
    , ST_ZHDR = 3'd5
`endif
  } state_t;

  // One code symbol plus its already bit-reversed extra bits.
  typedef struct packed {
    logic [8:0]  code;
    logic [3:0]  nbits;
    logic [15:0] extra;
    logic [3:0]  ebits;
  } sym_field_t;

  localparam logic [8:0]  SYM_EOB    = 9'd256;
  localparam logic [8:0]  SYM_LEN0   = 9'd257;
  localparam logic [8:0]  SYM_LENMAX = 9'd285;
  localparam logic [8:0]  LIT_LO_MAX = 9'd143;
  localparam logic [8:0]  LIT_HI_MAX = 9'd255;
  localparam logic [8:0]  LEN_LO_MAX = 9'd279;
  localparam logic [1:0]  HDR_BTYPE  = 2'b10;
  localparam logic [4:0]  HDR_NUMB   = 5'd2;
  localparam logic [4:0]  EOB_NUMB   = 5'd6;
  localparam logic [31:0] ZLIB_DAT   = 32'h0000_1E80;
  localparam logic [4:0]  ZLIB_NUMB  = 5'd15;

  function automatic logic [3:0] flog2_16(input logic [15:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  // Reverse the low n bits of x; the stream sends extra bits LSB-first.
  function automatic logic [15:0] bitrev16(input logic [15:0] x, input logic [3:0] n);
    logic [15:0] m;
    logic [15:0] r;
    m = x & ((16'd1 << n) - 16'd1);
    for (int i = 0; i < 16; i++) begin
      r[i] = m[15-i];
    end
    return r >> (5'd16 - {1'b0, n});
  endfunction

  function automatic sym_field_t lit_len_code(input logic [8:0] sym);
    sym_field_t f;
    f.extra = 16'd0;
    f.ebits = 4'd0;
    if (sym <= LIT_LO_MAX) begin
      f.code  = 9'h030 + sym;
      f.nbits = 4'd8;
    end else if (sym <= LIT_HI_MAX) begin
      f.code  = 9'h190 + (sym - 9'd144);
      f.nbits = 4'd9;
    end else if (sym <= LEN_LO_MAX) begin
      f.code  = sym - SYM_EOB;
      f.nbits = 4'd7;
    end else begin
      f.code  = 9'h0C0 + (sym - 9'd280);
      f.nbits = 4'd8;
    end
    return f;
  endfunction

  function automatic logic [31:0] pack_field(input sym_field_t f);
    return ({23'd0, f.code} << f.ebits) | {16'd0, f.extra};
  endfunction

  function automatic logic [4:0] field_numb(input sym_field_t f);
    return {1'b0, f.nbits} + {1'b0, f.ebits} - 5'd1;
  endfunction

endpackage

// File: rtl/huff_len_dist_map.sv
// Combinational match length / distance to fixed-Huffman symbol, code and reversed extra-bits mapper.
module huff_len_dist_map
  import huff_fix_pkg::*;
#(
  parameter int LEN_WD  = 9,
  parameter int DIST_WD = 16
) (
  input  logic [LEN_WD-1:0]  i_len,
  input  logic [DIST_WD-1:0] i_dist,
  output sym_field_t         o_len_fld,
  output sym_field_t         o_dist_fld
);

  logic [LEN_WD-1:0]  w_l;
  logic [15:0]        w_l16;
  logic [3:0]         w_llg;
  logic [3:0]         w_le;
  logic [8:0]         w_lsym;
  logic [15:0]        w_lx;
  logic [DIST_WD-1:0] w_d;
  logic [15:0]        w_d16;
  logic [3:0]         w_dlg;
  logic [3:0]         w_de;
  logic [4:0]         w_dcode;
  logic [15:0]        w_dx;

  assign w_l   = i_len - LEN_WD'(3);
  assign w_l16 = 16'(w_l);
  assign w_llg = flog2_16(w_l16);
  assign w_d   = i_dist - DIST_WD'(1);
  assign w_d16 = 16'(w_d);
  assign w_dlg = flog2_16(w_d16);

  // Length: L=len-3; 258 gets its own symbol, out-of-range values just wrap.
  always_comb begin
    w_lsym = SYM_LEN0;
    w_le   = 4'd0;
    if (w_l16 < 16'd8) begin
      w_lsym = SYM_LEN0 + w_l16[8:0];
      w_le   = 4'd0;
    end else if (w_l16 == 16'd255) begin
      w_lsym = SYM_LENMAX;
      w_le   = 4'd0;
    end else begin
      w_le   = w_llg - 4'd2;
      w_lsym = SYM_LEN0 + ((9'(w_le) + 9'd1) << 2) + 9'((w_l16 >> w_le) & 16'd3);
    end
    w_lx      = w_l16 & ((16'd1 << w_le) - 16'd1);
    o_len_fld = lit_len_code(w_lsym);
    o_len_fld.extra = bitrev16(w_lx, w_le);
    o_len_fld.ebits = w_le;
  end

  // Distance: D=dist-1 with a 5-bit fixed code.
  always_comb begin
    w_dcode = 5'd0;
    w_de    = 4'd0;
    if (w_d16 < 16'd4) begin
      w_dcode = w_d16[4:0];
      w_de    = 4'd0;
    end else begin
      w_de    = w_dlg - 4'd1;
      w_dcode = ((5'(w_de) + 5'd1) << 1) + 5'((w_d16 >> w_de) & 16'd1);
    end
    w_dx             = w_d16 & ((16'd1 << w_de) - 16'd1);
    o_dist_fld.code  = {4'd0, w_dcode};
    o_dist_fld.nbits = 4'd5;
    o_dist_fld.extra = bitrev16(w_dx, w_de);
    o_dist_fld.ebits = w_de;
  end

endmodule

// File: rtl/huff_fix_enc.sv
// Fixed-Huffman deflate token encoder: LZ77 tokens in, right-aligned MSB-first bit fields out.
// HUFF_FIX_ZLIB_HDR_EN inserts a zlib CMF/FLG field ahead of the block header.
module huff_fix_enc
  import huff_fix_pkg::*;
#(
  parameter int DATA_WD = 32,
  parameter int NUMB_WD = 5,
  parameter int LEN_WD  = 9,
  parameter int DIST_WD = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               bfinal_i,
  input  logic               val_i,
  output logic               rdy_o,
  input  logic               typ_i,
  input  logic [7:0]         lit_i,
  input  logic [LEN_WD-1:0]  len_i,
  input  logic [DIST_WD-1:0] dist_i,
  input  logic               last_i,
  output logic               val_o,
  output logic [DATA_WD-1:0] dat_o,
  output logic [NUMB_WD-1:0] numb_o,
  output logic               done_o
);

  state_t             r_state;
  state_t             w_next;
  logic               r_bfinal;
  logic               r_last;
  logic [DIST_WD-1:0] r_dist;
  logic               r_val;
  logic [DATA_WD-1:0] r_dat;
  logic [NUMB_WD-1:0] r_numb;
  logic               r_done;
  logic               r_rdy;
  logic               w_val;
  logic [DATA_WD-1:0] w_dat;
  logic [NUMB_WD-1:0] w_numb;
  logic               w_done;
  logic               w_acc;
  sym_field_t         w_len_fld;
  sym_field_t         w_dist_fld;
  sym_field_t         w_lit_fld;

  assign w_acc     = val_i & r_rdy;
  assign w_lit_fld = lit_len_code({1'b0, lit_i});

  // Length comes straight from the accepted token; distance from the copy held for DST.
  huff_len_dist_map #(
    .LEN_WD  (LEN_WD),
    .DIST_WD (DIST_WD)
  ) u_map (
    .i_len      (len_i),
    .i_dist     (r_dist),
    .o_len_fld  (w_len_fld),
    .o_dist_fld (w_dist_fld)
  );

  always_comb begin
    w_next = r_state;
    w_val  = 1'b0;
    w_dat  = '0;
    w_numb = '0;
    w_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
`ifdef HUFF_FIX_ZLIB_HDR_EN
          w_next = ST_ZHDR;
`else
          w_next = ST_HDR;
`endif
        end else begin
          w_next = ST_IDLE;
        end
      end
`ifdef HUFF_FIX_ZLIB_HDR_EN
      ST_ZHDR: begin
        w_val  = 1'b1;
        w_dat  = DATA_WD'(ZLIB_DAT);
        w_numb = NUMB_WD'(ZLIB_NUMB);
        w_next = ST_HDR;
      end
`endif
      ST_HDR: begin
        w_val  = 1'b1;
        w_dat  = DATA_WD'({r_bfinal, HDR_BTYPE});
        w_numb = NUMB_WD'(HDR_NUMB);
        w_next = ST_TOK;
      end
      ST_TOK: begin
        if (w_acc && typ_i) begin
          w_val  = 1'b1;
          w_dat  = DATA_WD'(pack_field(w_len_fld));
          w_numb = NUMB_WD'(field_numb(w_len_fld));
          w_next = ST_DST;
        end else if (w_acc) begin
          w_val  = 1'b1;
          w_dat  = DATA_WD'(pack_field(w_lit_fld));
          w_numb = NUMB_WD'(field_numb(w_lit_fld));
          w_next = last_i ? ST_EOB : ST_TOK;
        end else begin
          w_next = ST_TOK;
        end
      end
      ST_DST: begin
        w_val  = 1'b1;
        w_dat  = DATA_WD'(pack_field(w_dist_fld));
        w_numb = NUMB_WD'(field_numb(w_dist_fld));
        w_next = r_last ? ST_EOB : ST_TOK;
      end
      ST_EOB: begin
        w_val  = 1'b1;
        w_dat  = '0;
        w_numb = NUMB_WD'(EOB_NUMB);
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // State, token side-data and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bfinal <= 1'b0;
      r_last   <= 1'b0;
      r_dist   <= '0;
      r_val    <= 1'b0;
      r_dat    <= '0;
      r_numb   <= '0;
      r_done   <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && start_i) begin
        r_bfinal <= bfinal_i;
      end
      if (r_state == ST_TOK && w_acc && typ_i) begin
        r_last <= last_i;
        r_dist <= dist_i;
      end
      r_val  <= w_val;
      r_dat  <= w_dat;
      r_numb <= w_numb;
      r_done <= w_done;
      r_rdy  <= (w_next == ST_TOK);
    end
  end

  assign rdy_o  = r_rdy;
  assign val_o  = r_val;
  assign dat_o  = r_dat;
  assign numb_o = r_numb;
  assign done_o = r_done;

endmodule

// File: tb/tb_huff_fix_enc.sv
// Directed self-checking bench for huff_fix_enc (follows HUFF_FIX_ZLIB_HDR_EN when defined).
module tb_huff_fix_enc;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        bfinal_i;
  logic        val_i;
  logic        rdy_o;
  logic        typ_i;
  logic [7:0]  lit_i;
  logic [8:0]  len_i;
  logic [15:0] dist_i;
  logic        last_i;
  logic        val_o;
  logic [31:0] dat_o;
  logic [4:0]  numb_o;
  logic        done_o;

  int n_checks;
  int n_fail;

  huff_fix_enc dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .bfinal_i (bfinal_i),
    .val_i    (val_i),
    .rdy_o    (rdy_o),
    .typ_i    (typ_i),
    .lit_i    (lit_i),
    .len_i    (len_i),
    .dist_i   (dist_i),
    .last_i   (last_i),
    .val_o    (val_o),
    .dat_o    (dat_o),
    .numb_o   (numb_o),
    .done_o   (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_field(input string tag, input logic [31:0] d, input logic [4:0] n);
    chk({tag, ".val"}, 32'(val_o), 32'd1);
    chk({tag, ".dat"}, dat_o, d);
    chk({tag, ".numb"}, 32'(numb_o), 32'(n));
    chk({tag, ".done"}, 32'(done_o), 32'd0);
  endtask

  task automatic hdr_start(input logic bf, input logic [31:0] exp_dat);
    start_i  = 1'b1;
    bfinal_i = bf;
    tick();
    start_i  = 1'b0;
    bfinal_i = 1'b0;
    chk("start.val", 32'(val_o), 32'd0);
    chk("start.rdy", 32'(rdy_o), 32'd0);
`ifdef HUFF_FIX_ZLIB_HDR_EN
    tick();
    chk_field("zhdr", 32'h1E80, 5'd15);
    chk("zhdr.rdy", 32'(rdy_o), 32'd0);
`endif
    tick();
    chk_field("hdr", exp_dat, 5'd2);
    chk("hdr.rdy", 32'(rdy_o), 32'd1);
  endtask

  task automatic send_lit(input logic [7:0] l, input logic lst, input logic [31:0] d, input logic [4:0] n);
    val_i  = 1'b1;
    typ_i  = 1'b0;
    lit_i  = l;
    last_i = lst;
    tick();
    val_i  = 1'b0;
    last_i = 1'b0;
    chk_field("lit", d, n);
    chk("lit.rdy", 32'(rdy_o), lst ? 32'd0 : 32'd1);
  endtask

  task automatic send_match(input logic [8:0] ln, input logic [15:0] ds, input logic lst,
                            input logic [31:0] d1, input logic [4:0] n1,
                            input logic [31:0] d2, input logic [4:0] n2);
    val_i  = 1'b1;
    typ_i  = 1'b1;
    len_i  = ln;
    dist_i = ds;
    last_i = lst;
    tick();
    val_i  = 1'b0;
    typ_i  = 1'b0;
    last_i = 1'b0;
    len_i  = 9'd0;
    dist_i = 16'd0;
    chk_field("len", d1, n1);
    chk("dst.rdy", 32'(rdy_o), 32'd0);
    tick();
    chk_field("dist", d2, n2);
    chk("post.rdy", 32'(rdy_o), lst ? 32'd0 : 32'd1);
  endtask

  task automatic expect_eob();
    tick();
    chk("eob.val", 32'(val_o), 32'd1);
    chk("eob.dat", dat_o, 32'd0);
    chk("eob.numb", 32'(numb_o), 32'd6);
    chk("eob.done", 32'(done_o), 32'd1);
    tick();
    chk("idle.val", 32'(val_o), 32'd0);
    chk("idle.done", 32'(done_o), 32'd0);
    chk("idle.rdy", 32'(rdy_o), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start_i  = 1'b0;
    bfinal_i = 1'b0;
    val_i    = 1'b0;
    typ_i    = 1'b0;
    lit_i    = 8'd0;
    len_i    = 9'd0;
    dist_i   = 16'd0;
    last_i   = 1'b0;
    tick();
    tick();
    chk("rst.val", 32'(val_o), 32'd0);
    chk("rst.dat", dat_o, 32'd0);
    chk("rst.numb", 32'(numb_o), 32'd0);
    chk("rst.done", 32'(done_o), 32'd0);
    chk("rst.rdy", 32'(rdy_o), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle0.val", 32'(val_o), 32'd0);

    // Block 1: BFINAL=1, single literal 'A' then EOB.
    hdr_start(1'b1, 32'h6);
    send_lit(8'h41, 1'b1, 32'h71, 5'd7);
    expect_eob();

    // Block 2: BFINAL=0, literal range edges and the length/distance corners.
    hdr_start(1'b0, 32'h2);
    send_lit(8'hFF, 1'b0, 32'h1FF, 5'd8);
    send_lit(8'h8F, 1'b0, 32'hBF, 5'd7);
    send_lit(8'h90, 1'b0, 32'h190, 5'd8);
    send_lit(8'h00, 1'b0, 32'h30, 5'd7);

    // A token offered during DST must wait and then be taken exactly once.
    val_i  = 1'b1;
    typ_i  = 1'b1;
    len_i  = 9'd3;
    dist_i = 16'd1;
    tick();
    chk_field("m3.len", 32'h01, 5'd6);
    chk("m3.rdy", 32'(rdy_o), 32'd0);
    typ_i = 1'b0;
    lit_i = 8'h00;
    tick();
    chk_field("m3.dist", 32'h00, 5'd4);
    chk("m3.rdy2", 32'(rdy_o), 32'd1);
    tick();
    val_i = 1'b0;
    chk_field("held.lit", 32'h30, 5'd7);
    tick();
    chk("held.once", 32'(val_o), 32'd0);

    // start_i outside IDLE is ignored.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("ign.val", 32'(val_o), 32'd0);
    chk("ign.rdy", 32'(rdy_o), 32'd1);

    send_match(9'd11, 16'd5, 1'b0, 32'h12, 5'd7, 32'h08, 5'd5);
    send_match(9'd10, 16'd4, 1'b0, 32'h08, 5'd6, 32'h03, 5'd4);
    send_match(9'd258, 16'd32768, 1'b1, 32'hC5, 5'd7, 32'h3BFFF, 5'd17);
    expect_eob();

    // Reset in the middle of a match, then a clean block.
    hdr_start(1'b1, 32'h6);
    val_i  = 1'b1;
    typ_i  = 1'b1;
    len_i  = 9'd11;
    dist_i = 16'd5;
    tick();
    val_i = 1'b0;
    typ_i = 1'b0;
    chk_field("mr.len", 32'h12, 5'd7);
    rst = 1'b1;
    #1;
    chk("mr.val", 32'(val_o), 32'd0);
    chk("mr.dat", dat_o, 32'd0);
    chk("mr.numb", 32'(numb_o), 32'd0);
    chk("mr.done", 32'(done_o), 32'd0);
    chk("mr.rdy", 32'(rdy_o), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mr.idle", 32'(val_o), 32'd0);
    hdr_start(1'b1, 32'h6);
    send_lit(8'h41, 1'b1, 32'h71, 5'd7);
    expect_eob();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
